// File: rtl/writeback_unit.sv
// Writeback stage: turns retiring execute-stage results into register-file writes,
// sequencing loads through a request/acknowledge memory read with a timeout.
module writeback_unit #(
   parameter int DATA_W         = 8,
   parameter int SEL_W          = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_Valid,
   output logic              o_Ready,
   input  logic              i_Wb_En,
   input  logic              i_UseMem,
   input  logic [SEL_W-1:0]  i_Dest,
   input  logic [DATA_W-1:0] i_Alu_Result,
   output logic              o_Mem_Req,
   output logic [DATA_W-1:0] o_Mem_Addr,
   input  logic              i_Mem_Ack,
   input  logic [DATA_W-1:0] i_Mem_Data,
   output logic              o_Write_En,
   output logic [SEL_W-1:0]  o_Write_Sel,
   output logic [DATA_W-1:0] o_Write_Data,
   output logic              o_Pending_Valid,
   output logic [SEL_W-1:0]  o_Pending_Sel,
   output logic              o_Mem_Err
);

   // The counter only ever counts up to TIMEOUT_CYCLES-1 before the abort.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t              state_r, state_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic                write_en_r, write_en_s;
   logic [SEL_W-1:0]    write_sel_r, write_sel_s;
   logic [DATA_W-1:0]   write_data_r, write_data_s;
   logic                mem_req_r, mem_req_s;
   logic [DATA_W-1:0]   mem_addr_r, mem_addr_s;
   logic                pend_valid_r, pend_valid_s;
   logic [SEL_W-1:0]    pend_sel_r, pend_sel_s;
   logic                mem_err_r, mem_err_s;

   // Next-state and next-output decode; pulses default low, everything else holds.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      write_en_s   = 1'b0;
      write_sel_s  = write_sel_r;
      write_data_s = write_data_r;
      mem_req_s    = mem_req_r;
      mem_addr_s   = mem_addr_r;
      pend_valid_s = pend_valid_r;
      pend_sel_s   = pend_sel_r;
      mem_err_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_Valid) begin
               if (i_Wb_En) begin
                  if (i_UseMem) begin
                     mem_req_s    = 1'b1;
                     mem_addr_s   = i_Alu_Result;
                     pend_valid_s = 1'b1;
                     pend_sel_s   = i_Dest;
                     cnt_s        = {CNT_W{1'b0}};
                     state_s      = MEM_WAIT;
                  end else begin
                     write_en_s   = 1'b1;
                     write_sel_s  = i_Dest;
                     write_data_s = i_Alu_Result;
                  end
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         MEM_WAIT: begin
            // An ack in the expiry cycle takes priority over the abort.
            if (i_Mem_Ack) begin
               write_en_s   = 1'b1;
               write_sel_s  = pend_sel_r;
               write_data_s = i_Mem_Data;
               mem_req_s    = 1'b0;
               pend_valid_s = 1'b0;
               state_s      = IDLE;
            end else if (TIMEOUT_CYCLES != 0) begin
               if (cnt_r == CNT_LAST) begin
                  mem_err_s    = 1'b1;
                  mem_req_s    = 1'b0;
                  pend_valid_s = 1'b0;
                  state_s      = IDLE;
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end else begin
               state_s = MEM_WAIT;
            end
         end
         default: begin
            state_s      = IDLE;
            mem_req_s    = 1'b0;
            pend_valid_s = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         write_en_r   <= 1'b0;
         write_sel_r  <= {SEL_W{1'b0}};
         write_data_r <= {DATA_W{1'b0}};
         mem_req_r    <= 1'b0;
         mem_addr_r   <= {DATA_W{1'b0}};
         pend_valid_r <= 1'b0;
         pend_sel_r   <= {SEL_W{1'b0}};
         mem_err_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         write_en_r   <= write_en_s;
         write_sel_r  <= write_sel_s;
         write_data_r <= write_data_s;
         mem_req_r    <= mem_req_s;
         mem_addr_r   <= mem_addr_s;
         pend_valid_r <= pend_valid_s;
         pend_sel_r   <= pend_sel_s;
         mem_err_r    <= mem_err_s;
      end
   end

   assign o_Ready         = (state_r == IDLE);
   assign o_Write_En      = write_en_r;
   assign o_Write_Sel     = write_sel_r;
   assign o_Write_Data    = write_data_r;
   assign o_Mem_Req       = mem_req_r;
   assign o_Mem_Addr      = mem_addr_r;
   assign o_Pending_Valid = pend_valid_r;
   assign o_Pending_Sel   = pend_sel_r;
   assign o_Mem_Err       = mem_err_r;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with TIMEOUT_CYCLES=4: ALU writes, loads,
// timeout, ack-on-expiry and reset mid-load.
module tb_writeback_unit;

   logic       i_Clk;
   logic       i_Rst;
   logic       i_Valid;
   logic       o_Ready;
   logic       i_Wb_En;
   logic       i_UseMem;
   logic [1:0] i_Dest;
   logic [7:0] i_Alu_Result;
   logic       o_Mem_Req;
   logic [7:0] o_Mem_Addr;
   logic       i_Mem_Ack;
   logic [7:0] i_Mem_Data;
   logic       o_Write_En;
   logic [1:0] o_Write_Sel;
   logic [7:0] o_Write_Data;
   logic       o_Pending_Valid;
   logic [1:0] o_Pending_Sel;
   logic       o_Mem_Err;

   int total = 0;
   int bad   = 0;

   writeback_unit #(
      .DATA_W(8),
      .SEL_W(2),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .i_Clk(i_Clk),
      .i_Rst(i_Rst),
      .i_Valid(i_Valid),
      .o_Ready(o_Ready),
      .i_Wb_En(i_Wb_En),
      .i_UseMem(i_UseMem),
      .i_Dest(i_Dest),
      .i_Alu_Result(i_Alu_Result),
      .o_Mem_Req(o_Mem_Req),
      .o_Mem_Addr(o_Mem_Addr),
      .i_Mem_Ack(i_Mem_Ack),
      .i_Mem_Data(i_Mem_Data),
      .o_Write_En(o_Write_En),
      .o_Write_Sel(o_Write_Sel),
      .o_Write_Data(o_Write_Data),
      .o_Pending_Valid(o_Pending_Valid),
      .o_Pending_Sel(o_Pending_Sel),
      .o_Mem_Err(o_Mem_Err)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic tick();
      @(posedge i_Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Snapshot of a wait cycle: request, address and pending info all held, not ready.
   task automatic chk_wait(input string tag, input logic [7:0] addr, input logic [1:0] sel);
      chk({tag, "_req"},  32'(o_Mem_Req), 32'd1);
      chk({tag, "_addr"}, 32'(o_Mem_Addr), 32'(addr));
      chk({tag, "_pv"},   32'(o_Pending_Valid), 32'd1);
      chk({tag, "_psel"}, 32'(o_Pending_Sel), 32'(sel));
      chk({tag, "_rdy"},  32'(o_Ready), 32'd0);
      chk({tag, "_we"},   32'(o_Write_En), 32'd0);
      chk({tag, "_err"},  32'(o_Mem_Err), 32'd0);
   endtask

   initial begin
      i_Rst = 1'b1;
      i_Valid = 1'b0;
      i_Wb_En = 1'b0;
      i_UseMem = 1'b0;
      i_Dest = 2'd0;
      i_Alu_Result = 8'h00;
      i_Mem_Ack = 1'b0;
      i_Mem_Data = 8'h00;
      #1;
      chk("rst_rdy",  32'(o_Ready), 32'd1);
      chk("rst_we",   32'(o_Write_En), 32'd0);
      chk("rst_sel",  32'(o_Write_Sel), 32'd0);
      chk("rst_data", 32'(o_Write_Data), 32'd0);
      chk("rst_req",  32'(o_Mem_Req), 32'd0);
      chk("rst_addr", 32'(o_Mem_Addr), 32'd0);
      chk("rst_pv",   32'(o_Pending_Valid), 32'd0);
      chk("rst_psel", 32'(o_Pending_Sel), 32'd0);
      chk("rst_err",  32'(o_Mem_Err), 32'd0);
      tick();
      tick();
      i_Rst = 1'b0;
      tick();

      // Single ALU retire.
      i_Valid = 1'b1; i_Wb_En = 1'b1; i_UseMem = 1'b0; i_Dest = 2'd2; i_Alu_Result = 8'h5A;
      tick();
      i_Valid = 1'b0;
      chk("alu_we",   32'(o_Write_En), 32'd1);
      chk("alu_sel",  32'(o_Write_Sel), 32'd2);
      chk("alu_data", 32'(o_Write_Data), 32'h5A);
      chk("alu_rdy",  32'(o_Ready), 32'd1);
      tick();
      chk("alu_pulse", 32'(o_Write_En), 32'd0);

      // Back-to-back ALU retires, one write per cycle.
      for (int i = 0; i < 4; i++) begin
         i_Valid = 1'b1; i_Wb_En = 1'b1; i_UseMem = 1'b0;
         i_Dest = 2'(i); i_Alu_Result = 8'h10 + 8'(i);
         tick();
         chk("b2b_we",   32'(o_Write_En), 32'd1);
         chk("b2b_sel",  32'(o_Write_Sel), 32'(i));
         chk("b2b_data", 32'(o_Write_Data), 32'h10 + 32'(i));
         chk("b2b_rdy",  32'(o_Ready), 32'd1);
      end
      i_Valid = 1'b0;
      tick();
      chk("b2b_end_we", 32'(o_Write_En), 32'd0);

      // Wb_En=0 with UseMem=1 is consumed without a write or a memory request.
      i_Valid = 1'b1; i_Wb_En = 1'b0; i_UseMem = 1'b1; i_Dest = 2'd3; i_Alu_Result = 8'hEE;
      tick();
      i_Valid = 1'b0;
      chk("nowb_we",  32'(o_Write_En), 32'd0);
      chk("nowb_req", 32'(o_Mem_Req), 32'd0);
      chk("nowb_rdy", 32'(o_Ready), 32'd1);

      // Load acked in the third wait cycle; a stray ack in IDLE beforehand is ignored.
      i_Mem_Ack = 1'b1; i_Mem_Data = 8'h99;
      tick();
      i_Mem_Ack = 1'b0;
      chk("idle_ack_we", 32'(o_Write_En), 32'd0);
      i_Valid = 1'b1; i_Wb_En = 1'b1; i_UseMem = 1'b1; i_Dest = 2'd1; i_Alu_Result = 8'h80;
      tick();
      i_Valid = 1'b0;
      chk_wait("ld_w1", 8'h80, 2'd1);
      tick();
      chk_wait("ld_w2", 8'h80, 2'd1);
      tick();
      chk_wait("ld_w3", 8'h80, 2'd1);
      i_Mem_Ack = 1'b1; i_Mem_Data = 8'hC3;
      tick();
      i_Mem_Ack = 1'b0;
      chk("ld_we",   32'(o_Write_En), 32'd1);
      chk("ld_sel",  32'(o_Write_Sel), 32'd1);
      chk("ld_data", 32'(o_Write_Data), 32'hC3);
      chk("ld_req",  32'(o_Mem_Req), 32'd0);
      chk("ld_pv",   32'(o_Pending_Valid), 32'd0);
      chk("ld_rdy",  32'(o_Ready), 32'd1);
      chk("ld_addr_hold", 32'(o_Mem_Addr), 32'h80);
      chk("ld_psel_hold", 32'(o_Pending_Sel), 32'd1);
      tick();
      chk("ld_pulse", 32'(o_Write_En), 32'd0);

      // Timeout after four ack-less wait cycles; an ALU offer during the wait is ignored.
      i_Valid = 1'b1; i_Wb_En = 1'b1; i_UseMem = 1'b1; i_Dest = 2'd3; i_Alu_Result = 8'h44;
      tick();
      i_Valid = 1'b0;
      chk_wait("to_w1", 8'h44, 2'd3);
      i_Valid = 1'b1; i_UseMem = 1'b0; i_Dest = 2'd0; i_Alu_Result = 8'hFF;
      tick();
      chk_wait("to_w2", 8'h44, 2'd3);
      i_Valid = 1'b0;
      tick();
      chk_wait("to_w3", 8'h44, 2'd3);
      tick();
      chk_wait("to_w4", 8'h44, 2'd3);
      tick();
      chk("to_err", 32'(o_Mem_Err), 32'd1);
      chk("to_req", 32'(o_Mem_Req), 32'd0);
      chk("to_pv",  32'(o_Pending_Valid), 32'd0);
      chk("to_we",  32'(o_Write_En), 32'd0);
      chk("to_rdy", 32'(o_Ready), 32'd1);
      tick();
      chk("to_err_pulse", 32'(o_Mem_Err), 32'd0);

      // Ack arriving in the expiry cycle wins over the timeout.
      i_Valid = 1'b1; i_Wb_En = 1'b1; i_UseMem = 1'b1; i_Dest = 2'd0; i_Alu_Result = 8'h20;
      tick();
      i_Valid = 1'b0;
      chk_wait("ex_w1", 8'h20, 2'd0);
      tick();
      tick();
      tick();
      chk_wait("ex_w4", 8'h20, 2'd0);
      i_Mem_Ack = 1'b1; i_Mem_Data = 8'h77;
      tick();
      i_Mem_Ack = 1'b0;
      chk("ex_we",   32'(o_Write_En), 32'd1);
      chk("ex_sel",  32'(o_Write_Sel), 32'd0);
      chk("ex_data", 32'(o_Write_Data), 32'h77);
      chk("ex_err",  32'(o_Mem_Err), 32'd0);
      chk("ex_rdy",  32'(o_Ready), 32'd1);
      tick();

      // Reset mid-load clears everything at once; a late ack does nothing.
      i_Valid = 1'b1; i_Wb_En = 1'b1; i_UseMem = 1'b1; i_Dest = 2'd2; i_Alu_Result = 8'h99;
      tick();
      i_Valid = 1'b0;
      tick();
      chk_wait("rm_w2", 8'h99, 2'd2);
      i_Rst = 1'b1;
      #1;
      chk("rm_rdy",  32'(o_Ready), 32'd1);
      chk("rm_req",  32'(o_Mem_Req), 32'd0);
      chk("rm_addr", 32'(o_Mem_Addr), 32'd0);
      chk("rm_pv",   32'(o_Pending_Valid), 32'd0);
      chk("rm_psel", 32'(o_Pending_Sel), 32'd0);
      chk("rm_we",   32'(o_Write_En), 32'd0);
      chk("rm_data", 32'(o_Write_Data), 32'd0);
      chk("rm_err",  32'(o_Mem_Err), 32'd0);
      tick();
      i_Rst = 1'b0;
      i_Mem_Ack = 1'b1; i_Mem_Data = 8'hAB;
      tick();
      i_Mem_Ack = 1'b0;
      chk("rm_late_we",  32'(o_Write_En), 32'd0);
      chk("rm_late_err", 32'(o_Mem_Err), 32'd0);
      chk("rm_late_req", 32'(o_Mem_Req), 32'd0);
      chk("rm_late_rdy", 32'(o_Ready), 32'd1);
      tick();
      chk("rm_after_we",  32'(o_Write_En), 32'd0);
      chk("rm_after_err", 32'(o_Mem_Err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer-side counterpart of the 4-entry, 8-bit CPU register file: it produces the file's write enable, write select and write data.
- Accepts retiring instructions from the execute stage over a valid/ready handshake.
- ALU results are written directly; loads are sequenced through a request/acknowledge memory read with a timeout.
- Exposes the pending load destination so decode can stall on read-after-write hazards.

Parameters:
DATA_W, 8, register and memory data width
SEL_W, 2, register select width (4 registers)
TIMEOUT_CYCLES, 16, MEM_WAIT cycles without ack before abort; 0 disables the timeout

Ports:
i_Clk  input  1  system clock, rising edge
i_Rst  input  1  asynchronous, active-high reset
i_Valid  input  1  execute stage presents a retiring instruction
o_Ready  output  1  unit can accept; high exactly when state is IDLE
i_Wb_En  input  1  instruction writes a register
i_UseMem  input  1  result comes from memory (load); i_Alu_Result is the address
i_Dest  input  SEL_W  destination register
i_Alu_Result  input  DATA_W  ALU result or load address
o_Mem_Req  output  1  memory read request, held until ack or timeout
o_Mem_Addr  output  DATA_W  load address, stable while o_Mem_Req is high
i_Mem_Ack  input  1  memory data valid this cycle
i_Mem_Data  input  DATA_W  load data, sampled when i_Mem_Ack is high
o_Write_En  output  1  register file write strobe, one-cycle pulse
o_Write_Sel  output  SEL_W  register file write select
o_Write_Data  output  DATA_W  register file write data
o_Pending_Valid  output  1  a load to o_Pending_Sel is outstanding
o_Pending_Sel  output  SEL_W  destination of the outstanding load
o_Mem_Err  output  1  one-cycle pulse on load timeout

Behaviour:
- Reset (async, i_Rst=1):
  - state=IDLE, so o_Ready=1.
  - o_Write_En, o_Write_Sel, o_Write_Data, o_Mem_Req, o_Mem_Addr, o_Pending_Valid, o_Pending_Sel and o_Mem_Err are all 0.
  - Timeout counter is 0.
  - Reset mid-load abandons the load; no write and no error pulse occur.
- All outputs except o_Ready are registered.
- o_Write_En and o_Mem_Err default to 0 each cycle; they are pulses only.
- Accept occurs when i_Valid && o_Ready are both high at a rising edge.
- IDLE, on accept:
  - i_Wb_En=0: consumed, no write, remain IDLE.
  - i_Wb_En=1, i_UseMem=0: next cycle o_Write_En=1, o_Write_Sel=i_Dest, o_Write_Data=i_Alu_Result. Remain IDLE, so back-to-back ALU retires give one write per cycle (latency 1).
  - i_Wb_En=1, i_UseMem=1:
    - Next cycle o_Mem_Req=1, o_Mem_Addr=i_Alu_Result, o_Pending_Valid=1, o_Pending_Sel=i_Dest.
    - Counter cleared; go to MEM_WAIT, which drops o_Ready to 0.
  - i_Wb_En=0, i_UseMem=1: treated as no-write and consumed (stores are handled elsewhere).
- IDLE without accept: i_Mem_Ack is ignored.
- MEM_WAIT, each cycle:
  - i_Mem_Ack=1:
    - Next cycle o_Write_En=1, o_Write_Sel=o_Pending_Sel, o_Write_Data=i_Mem_Data.
    - o_Mem_Req=0, o_Pending_Valid=0, state=IDLE.
    - o_Ready=1 during the write cycle; an ALU accept there writes in the following cycle, so there is no collision.
  - No ack and TIMEOUT_CYCLES!=0:
    - Counter increments.
    - When the counter reaches TIMEOUT_CYCLES-1 without ack, next cycle o_Mem_Err=1, o_Mem_Req=0, o_Pending_Valid=0, no write, state=IDLE.
  - Ack in the same cycle as timeout expiry: ack wins; write occurs, no error.
  - i_Valid is ignored because o_Ready=0; execute must hold its inputs.
- Ack on the first MEM_WAIT cycle gives a minimum load-to-write latency of 2 cycles from accept.
- o_Mem_Addr and o_Pending_Sel hold their last values in IDLE.

Test Plan:
- Reset then ALU retire: accept Dest=2, Alu=0x5A, Wb_En=1, UseMem=0 -> next cycle Write_En=1, Sel=2, Data=0x5A; Ready stays 1.
- Back-to-back ALU retires: Dest 0..3 with data 0x10,0x11,0x12,0x13 on consecutive cycles -> four consecutive write pulses, in order, with matching Sel/Data.
- Load with delay: accept Dest=1, UseMem=1, Alu=0x80; ack after 3 wait cycles with Data=0xC3 ->
  - Mem_Req=1 with Addr=0x80 for 3 cycles.
  - Pending_Valid=1, Pending_Sel=1, Ready=0 throughout the wait.
  - One write (Sel=1, Data=0xC3), then Ready=1.
- Timeout: TIMEOUT_CYCLES=4, load with no ack -> after 4 MEM_WAIT cycles, Mem_Err pulses once, Req=0, no Write_En, Ready=1.
- Ack on expiry cycle: TIMEOUT_CYCLES=4, ack on the 4th wait cycle with 0x77 -> write of 0x77 occurs, Mem_Err stays 0.
- Reset mid-load: assert i_Rst during MEM_WAIT -> all outputs 0 immediately, Ready=1, no write after deassert; a late ack is ignored.
